// File: rtl/pe_xnor_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pe_xnor_seq_ctrl_pkg
// Shared definitions for the xnor PE sequencer slice.
//   BITS_SIP_DOT_ADDER : output width of the PE sip_dot_adder (psum width)
//   PSUM_W_DEF         : default psum width seen by the sequencer
//   ACC_W_DEF          : default signed accumulator / result width
//   KLEN_W_DEF         : default width of the beat-count field
//   state_e            : sequencer state encoding (IDLE/FEED/DRAIN/OUT)
//   sat_ovf()          : overflow test on the guard bits of a widened sum
// ---------------------------------------------------------------------------
package pe_xnor_seq_ctrl_pkg;

  localparam int BITS_SIP_DOT_ADDER = 8;

  localparam int PSUM_W_DEF = BITS_SIP_DOT_ADDER;
  localparam int ACC_W_DEF  = 24;
  localparam int KLEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // The sum carries two guard bits above the accumulator sign bit. The value
  // fits the accumulator only when the sign bit and both guard bits agree.
  function automatic logic sat_ovf(input logic [2:0] topBits);
    return !((topBits == 3'b000) || (topBits == 3'b111));
  endfunction

endpackage

// File: rtl/pe_xnor_seq_ctrl_accum.sv
// ---------------------------------------------------------------------------
// pe_psum_accum
// Saturating signed accumulator for PE partial sums.
//   CLK, RST  : clock, synchronous active-high reset
//   clr_i     : clear accumulator and sticky overflow (job start)
//   en_i      : add psum_i this cycle
//   shift_i   : weight psum_i by 2 (MSB bit-plane in 2-bit mode)
//   psum_i    : signed PE partial sum
//   acc_o     : signed accumulated value
//   ovf_o     : sticky saturation flag since the last clear
// ---------------------------------------------------------------------------
module pe_psum_accum
  import pe_xnor_seq_ctrl_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              shift_i,
  input  logic [PSUM_W-1:0] psum_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  localparam int SUM_W = ACC_W + 2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q;
  logic [SUM_W-1:0] accExt, addend, sum;
  logic             ovfNow;

  // Widen both operands so that a doubled MSB-plane psum added to a
  // full-scale accumulator can never wrap before the range check, then clamp
  // to the accumulator range, choosing the rail from the sign of the sum.
  always_comb begin
    accExt = {{2{acc_q[ACC_W-1]}}, acc_q};
    addend = {{(SUM_W-PSUM_W){psum_i[PSUM_W-1]}}, psum_i};
    if (shift_i) begin
      addend = {addend[SUM_W-2:0], 1'b0};
    end
    sum    = accExt + addend;
    ovfNow = sat_ovf(sum[SUM_W-1:ACC_W-1]);
    if (!ovfNow) begin
      acc_d = sum[ACC_W-1:0];
    end else if (sum[SUM_W-1]) begin
      acc_d = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_d = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Accumulator and sticky overflow. A clear wins over a same-cycle add,
  // which cannot happen in practice because clears occur only in IDLE.
  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      acc_q <= acc_d;
      if (ovfNow) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pe_xnor_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pe_xnor_seq_ctrl
// Job sequencer for one xnor processing element.
//   CLK, RST            : clock, synchronous active-high reset
//   cfg_start           : job start pulse (taken only in IDLE)
//   cfg_k_len           : operand beats in the job
//   cfg_mode            : 0 = single plane, 1 = two bit-planes per chunk
//   cfg_sign, cfg_bin   : latched to pe_signI / pe_bin for the job
//   in_valid / in_ready : operand beat handshake, pe_load = handshake
//   pe_psum             : registered PE partial sum (1 cycle after pe_load)
//   out_valid/out_ready : result handshake carrying out_acc and out_ovf
//   busy                : state is not IDLE
//   err_cfg             : one-cycle pulse after a rejected start
// ---------------------------------------------------------------------------
module pe_xnor_seq_ctrl
  import pe_xnor_seq_ctrl_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int KLEN_W = KLEN_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_start,
  input  logic [KLEN_W-1:0] cfg_k_len,
  input  logic              cfg_mode,
  input  logic              cfg_sign,
  input  logic              cfg_bin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pe_load,
  output logic              pe_bin,
  output logic              pe_signI,
  input  logic [PSUM_W-1:0] pe_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy,
  output logic              err_cfg
);

  state_e            state_q, state_d;
  logic [KLEN_W-1:0] cnt_q, cnt_d, kLen_q, cntInc;
  logic              mode_q, sign_q, bin_q;
  logic              accEn_q, shift_q, err_q;
  logic              startOk, startErr;

  // Next-state and handshake decode. A start is only looked at in IDLE, so
  // a start raised during FEED/DRAIN/OUT (including the OUT handshake cycle)
  // is silently dropped. A 2-bit job needs whole chunk pairs, so an odd
  // beat count in that mode is refused.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    startOk  = 1'b0;
    startErr = 1'b0;
    cntInc   = cnt_q + KLEN_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_mode && cfg_k_len[0]) begin
            startErr = 1'b1;
          end else begin
            startOk = 1'b1;
            cnt_d   = '0;
            state_d = (cfg_k_len == '0) ? ST_OUT : ST_FEED;
          end
        end
      end
      ST_FEED: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cntInc;
          if (cntInc == kLen_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pe_load = in_valid & in_ready;

  // State, beat counter and the latched job configuration. The accumulate
  // enable trails each accepted beat by one cycle to line up with the PE's
  // registered psum; the plane weight is captured with it from the beat
  // index, even beats being the MSB plane in 2-bit mode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kLen_q  <= '0;
      mode_q  <= 1'b0;
      sign_q  <= 1'b0;
      bin_q   <= 1'b0;
      accEn_q <= 1'b0;
      shift_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      accEn_q <= pe_load;
      shift_q <= mode_q & ~cnt_q[0];
      err_q   <= startErr;
      if (startOk) begin
        kLen_q <= cfg_k_len;
        mode_q <= cfg_mode;
        sign_q <= cfg_sign;
        bin_q  <= cfg_bin;
      end
    end
  end

  // The accumulator is cleared by the accepted start and fed by the
  // delayed enable, so the final psum lands during the DRAIN cycle.
  pe_psum_accum #(
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W)
  ) u_accum (
    .CLK     (CLK),
    .RST     (RST),
    .clr_i   (startOk),
    .en_i    (accEn_q),
    .shift_i (shift_q),
    .psum_i  (pe_psum),
    .acc_o   (out_acc),
    .ovf_o   (out_ovf)
  );

  assign pe_bin    = bin_q;
  assign pe_signI  = sign_q;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign err_cfg   = err_q;

endmodule

// File: tb/tb_pe_xnor_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_xnor_seq_ctrl
// Drives directed jobs into two sequencer instances sharing every input:
// the default 24-bit accumulator and a narrow 8-bit one that exercises
// saturation. A small PE model registers operand data on pe_load. Expected
// results are queued at stimulus time and popped by a monitor on each
// result handshake.
// ---------------------------------------------------------------------------
module tb_pe_xnor_seq_ctrl;

  localparam int PSUM_W = 8;
  localparam int KLEN_W = 8;

  typedef struct {
    int acc24;
    bit ovf24;
    int acc8;
    bit ovf8;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic              cfg_start, cfg_mode, cfg_sign, cfg_bin;
  logic [KLEN_W-1:0] cfg_k_len;
  logic              in_valid, out_ready;
  logic [PSUM_W-1:0] pe_psum, opData;

  logic              inReadyA, peLoadA, peBinA, peSignA, outValidA, outOvfA;
  logic              busyA, errA;
  logic [23:0]       outAccA;
  logic              inReadyB, peLoadB, peBinB, peSignB, outValidB, outOvfB;
  logic              busyB, errB;
  logic [7:0]        outAccB;

  int   cycleCnt = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   psumTab[16];
  exp_t expQ[$];
  exp_t monE;

  pe_xnor_seq_ctrl #(.PSUM_W(PSUM_W), .ACC_W(24), .KLEN_W(KLEN_W)) dut (
    .CLK(CLK), .RST(RST), .cfg_start(cfg_start), .cfg_k_len(cfg_k_len),
    .cfg_mode(cfg_mode), .cfg_sign(cfg_sign), .cfg_bin(cfg_bin),
    .in_valid(in_valid), .in_ready(inReadyA), .pe_load(peLoadA),
    .pe_bin(peBinA), .pe_signI(peSignA), .pe_psum(pe_psum),
    .out_valid(outValidA), .out_ready(out_ready), .out_acc(outAccA),
    .out_ovf(outOvfA), .busy(busyA), .err_cfg(errA)
  );

  pe_xnor_seq_ctrl #(.PSUM_W(PSUM_W), .ACC_W(8), .KLEN_W(KLEN_W)) dutSat (
    .CLK(CLK), .RST(RST), .cfg_start(cfg_start), .cfg_k_len(cfg_k_len),
    .cfg_mode(cfg_mode), .cfg_sign(cfg_sign), .cfg_bin(cfg_bin),
    .in_valid(in_valid), .in_ready(inReadyB), .pe_load(peLoadB),
    .pe_bin(peBinB), .pe_signI(peSignB), .pe_psum(pe_psum),
    .out_valid(outValidB), .out_ready(out_ready), .out_acc(outAccB),
    .out_ovf(outOvfB), .busy(busyB), .err_cfg(errB)
  );

  // Free-running clock and edge counter used for latency measurement.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  // PE model: operand data is captured on pe_load and appears as the psum
  // one cycle later, holding its value until the next load.
  always @(posedge CLK) begin
    if (RST) begin
      pe_psum <= '0;
    end else if (peLoadA) begin
      pe_psum <= opData;
    end
  end

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every result handshake pops one expected entry and compares
  // both instances, which run in lockstep on the shared inputs.
  always @(negedge CLK) begin
    if (!RST && outValidA && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("out_acc24", $signed(outAccA), monE.acc24);
        checkOutput("out_ovf24", outOvfA, monE.ovf24);
        checkOutput("out_valid8", outValidB, 1);
        checkOutput("out_acc8", $signed(outAccB), monE.acc8);
        checkOutput("out_ovf8", outOvfB, monE.ovf8);
      end
    end
  end

  // One job: raise start, feed psumTab beats (optionally stalling or
  // raising a stray start mid-job), wait for the result, optionally hold
  // out_ready low, then complete the handshake. Called at posedge+1.
  task automatic applyStimulus(input int kLen, input bit mode, input bit sgn, input bit bin,
                               input int stallBeat, input int stallLen, input bit midStart,
                               input int holdReady, input int expLat,
                               input int acc24, input bit ovf24, input int acc8, input bit ovf8);
    int   beat, stalls, e0, waitCnt;
    bit   seen;
    exp_t e;
    e.acc24 = acc24; e.ovf24 = ovf24; e.acc8 = acc8; e.ovf8 = ovf8;
    expQ.push_back(e);
    out_ready = (holdReady == 0);
    cfg_k_len = kLen[KLEN_W-1:0];
    cfg_mode  = mode;
    cfg_sign  = sgn;
    cfg_bin   = bin;
    cfg_start = 1'b1;
    e0 = cycleCnt;
    @(posedge CLK); #1;
    cfg_start = 1'b0;
    beat = 0;
    stalls = 0;
    while (beat < kLen) begin
      if (beat == stallBeat && stalls < stallLen) begin
        in_valid = 1'b0;
        stalls++;
      end else begin
        in_valid = 1'b1;
        opData   = psumTab[beat][PSUM_W-1:0];
      end
      if (midStart && beat == 1) begin
        cfg_start = 1'b1;
        cfg_k_len = 1;
        cfg_mode  = 1'b0;
        cfg_sign  = ~sgn;
        cfg_bin   = ~bin;
      end
      @(negedge CLK);
      if (beat == 0 && in_valid) begin
        checkOutput("in_ready_feed", inReadyA, 1);
        checkOutput("pe_bin_feed", peBinA, bin);
        checkOutput("pe_signI_feed", peSignA, sgn);
      end
      @(posedge CLK); #1;
      cfg_start = 1'b0;
      if (in_valid) beat++;
    end
    in_valid = 1'b0;
    if (kLen > 0) begin
      @(negedge CLK);
      checkOutput("in_ready_drain", inReadyA, 0);
      if (midStart) begin
        checkOutput("pe_bin_drain", peBinA, bin);
        checkOutput("pe_signI_drain", peSignA, sgn);
      end
    end
    seen = 1'b0;
    waitCnt = 0;
    while (!seen && waitCnt < 20) begin
      if (outValidA) begin
        seen = 1'b1;
      end else begin
        @(negedge CLK);
        waitCnt++;
      end
    end
    if (!seen) begin
      checkOutput("result_timeout", 0, 1);
    end else begin
      if (expLat > 0) checkOutput("latency", cycleCnt - e0, expLat);
      if (holdReady > 0) begin
        repeat (holdReady) begin
          @(negedge CLK);
          checkOutput("hold_valid", outValidA, 1);
          checkOutput("hold_acc", $signed(outAccA), acc24);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1;
        cfg_start = 1'b1;
        cfg_k_len = 2;
        cfg_mode  = 1'b0;
        @(posedge CLK); #1;
        cfg_start = 1'b0;
        @(negedge CLK);
        checkOutput("start_at_out_hs_ignored", busyA, 0);
        @(posedge CLK); #1;
      end else begin
        @(posedge CLK); #1;
      end
    end
  endtask

  // Main sequence of directed jobs.
  initial begin
    int pulses, busyHi;
    RST = 1'b1;
    cfg_start = 1'b0; cfg_k_len = '0; cfg_mode = 1'b0;
    cfg_sign = 1'b1; cfg_bin = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; opData = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_out_valid", outValidA, 0);
    checkOutput("rst_in_ready", inReadyA, 0);
    checkOutput("rst_pe_load", peLoadA, 0);
    checkOutput("rst_err_cfg", errA, 0);
    checkOutput("rst_pe_bin", peBinA, 0);
    checkOutput("rst_pe_signI", peSignA, 0);
    checkOutput("rst_out_acc", outAccA, 0);
    checkOutput("rst_out_ovf", outOvfA, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    psumTab[0] = 3; psumTab[1] = -1; psumTab[2] = 5; psumTab[3] = 2;
    applyStimulus(4, 0, 1, 0, -1, 0, 0, 0, 6, 9, 0, 9, 0);

    psumTab[0] = 2; psumTab[1] = 1; psumTab[2] = -3; psumTab[3] = 4;
    applyStimulus(4, 1, 0, 1, -1, 0, 0, 0, 6, 3, 0, 3, 0);

    psumTab[0] = 1; psumTab[1] = 1; psumTab[2] = 1;
    applyStimulus(3, 0, 0, 0, 1, 2, 0, 0, 7, 3, 0, 3, 0);

    psumTab[0] = 100; psumTab[1] = 100; psumTab[2] = 100;
    applyStimulus(3, 0, 0, 0, -1, 0, 0, 0, 5, 300, 0, 127, 1);

    psumTab[0] = 1;
    applyStimulus(1, 0, 0, 0, -1, 0, 0, 0, 3, 1, 0, 1, 0);

    psumTab[0] = -100; psumTab[1] = -100;
    applyStimulus(2, 1, 1, 1, -1, 0, 0, 0, 4, -300, 0, -128, 1);

    cfg_k_len = 3; cfg_mode = 1'b1; cfg_start = 1'b1;
    @(posedge CLK); #1;
    cfg_start = 1'b0; cfg_mode = 1'b0;
    pulses = 0;
    busyHi = 0;
    repeat (4) begin
      @(negedge CLK);
      pulses += int'(errA);
      busyHi += int'(busyA);
    end
    checkOutput("err_cfg_pulses", pulses, 1);
    checkOutput("err_cfg_busy", busyHi, 0);
    @(posedge CLK); #1;

    applyStimulus(0, 0, 0, 0, -1, 0, 0, 3, 1, 0, 0, 0, 0);

    psumTab[0] = 5; psumTab[1] = 6; psumTab[2] = 7;
    applyStimulus(3, 0, 0, 0, -1, 0, 1, 0, 5, 18, 0, 18, 0);

    cfg_k_len = 4; cfg_mode = 1'b0; cfg_start = 1'b1;
    @(posedge CLK); #1;
    cfg_start = 1'b0;
    in_valid = 1'b1; opData = 8'd10;
    @(posedge CLK); #1;
    opData = 8'd20;
    @(posedge CLK); #1;
    RST = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("abort_busy", busyA, 0);
    checkOutput("abort_out_valid", outValidA, 0);
    checkOutput("abort_out_acc", outAccA, 0);
    repeat (3) @(posedge CLK);
    #1;

    psumTab[0] = 7;
    applyStimulus(1, 0, 0, 0, -1, 0, 0, 0, 3, 7, 0, 7, 0);

    repeat (3) @(posedge CLK);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
